// File: rtl/sap_core_param.sv
// SAP-1 style accumulator core: 6-cycle fetch/execute FSM, internal RAM, program-load mode.
// Optional SAP_JUMP_EN enables JMP/JC/JZ; without it opcodes 0x5-0x7 execute as NOPs.
module sap_core_param #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              prog_mode,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic              flag_z,
   output logic              flag_c
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, HALT, LOAD} state_t;
   typedef enum logic [3:0] {
      OP_LDA = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_STA = 4'h3,
      OP_LDI = 4'h4, OP_JMP = 4'h5, OP_JC  = 4'h6, OP_JZ  = 4'h7,
      OP_OUT = 4'hE, OP_HLT = 4'hF
   } opcode_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir, acc, b_reg, ram_rdata;
   logic [DATA_W-1:0] ram [DEPTH];
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W:0]   alu_sum;
   logic              take_jump;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic              unused_ir;

   assign opcode    = ir[DATA_W-1 -: 4];
   assign operand   = ir[ADDR_W-1:0];
   assign unused_ir = ^ir;
   assign ram_rdata = ram[mar];
   assign out_valid = (state == T5) && (opcode == OP_OUT);

   // SUB adds the two's complement of B, so the carry out means ACC >= B.
   always_comb begin
      if (opcode == OP_SUB)
         alu_sum = {1'b0, acc} + {1'b0, ~b_reg} + {{DATA_W{1'b0}}, 1'b1};
      else
         alu_sum = {1'b0, acc} + {1'b0, b_reg};
   end

   // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
   always_comb begin
      take_jump = 1'b0;
`ifdef SAP_JUMP_EN
      case (opcode)
         OP_JMP:  take_jump = 1'b1;
         OP_JC:   take_jump = flag_c;
         OP_JZ:   take_jump = flag_z;
         default: take_jump = 1'b0;
      endcase
`endif
   end

   always_comb begin
      state_next = state;
      case (state)
         T1:      state_next = T2;
         T2:      state_next = T3;
         T3:      state_next = T4;
         T4:      state_next = (opcode == OP_HLT) ? HALT : T5;
         T5:      state_next = T6;
         T6:      state_next = T1;
         HALT:    state_next = HALT;
         LOAD:    state_next = T1;
         default: state_next = T1;
      endcase
      if (prog_mode) state_next = LOAD;
   end

   // Program writes own the port in LOAD; an aborting prog_mode also kills a pending STA.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = mar;
      ram_wdata = acc;
      if (state == LOAD) begin
         ram_we    = prog_we;
         ram_waddr = prog_addr;
         ram_wdata = prog_data;
      end else if ((state == T5) && (opcode == OP_STA) && !prog_mode) begin
         ram_we = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= T1;
         pc     <= '0;
         mar    <= '0;
         ir     <= '0;
         acc    <= '0;
         b_reg  <= '0;
         out    <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         halted <= (state == HALT) && !prog_mode;
         if (!prog_mode) begin
            case (state)
               T1: mar <= pc;
               T2: pc  <= pc + ADDR_W'(1);
               T3: ir  <= ram_rdata;
               T4: begin
                  case (opcode)
                     OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                     OP_LDI:  acc <= DATA_W'(operand);
                     OP_OUT:  out <= acc;
                     default: ;
                  endcase
                  if (take_jump) pc <= operand;
               end
               T5: begin
                  if (opcode == OP_LDA) acc <= ram_rdata;
                  if ((opcode == OP_ADD) || (opcode == OP_SUB)) b_reg <= ram_rdata;
               end
               T6: begin
                  if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                     {flag_c, acc} <= alu_sum;
                     flag_z        <= (alu_sum[DATA_W-1:0] == '0);
                  end
               end
               LOAD: begin
                  // Leaving program mode restarts from address 0; out is deliberately kept.
                  pc     <= '0;
                  mar    <= '0;
                  ir     <= '0;
                  acc    <= '0;
                  b_reg  <= '0;
                  flag_z <= 1'b0;
                  flag_c <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: the RAM has no reset; its contents must survive clr.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
   end

endmodule

// File: doc/sap_core_param.md
SAP_CORE_PARAM -- requirements
Module: sap_core_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data path, accumulator, register and RAM word width.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning PC, MAR and operand width; RAM depth is 2^ADDR_W.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: clk is the single clock and clr is the reset, asserted at 0.
REQ-004 The block SHALL have these ports, one per line as name, direction, width, meaning:
 clk  in  1  rising-edge clock
 clr  in  1  asynchronous active-low reset
 prog_mode  in  1  1 = halt execution and accept program writes
 prog_we  in  1  RAM write strobe, honoured only in LOAD
 prog_addr  in  ADDR_W  program write address
 prog_data  in  DATA_W  program write data
 out  out  DATA_W  output register
 out_valid  out  1  one-cycle pulse on each OUT update
 halted  out  1  1 while in HALT
 pc  out  ADDR_W  current program counter
 flag_z  out  1  zero flag
 flag_c  out  1  carry flag
REQ-005 DATA_W SHALL be at least ADDR_W+4; instruction = opcode in bits [DATA_W-1:DATA_W-4], operand in bits [ADDR_W-1:0], other bits ignored.

Function
REQ-006 FSM states SHALL be T1, T2, T3, T4, T5, T6, HALT and LOAD; every instruction takes exactly 6 cycles, T1 to T6 then T1.
REQ-007 Fetch SHALL be: T1 MAR<=PC; T2 PC<=PC+1, wrapping from 2^ADDR_W-1 to 0; T3 IR<=RAM[MAR].
REQ-008 RAM read SHALL be combinational from MAR; RAM write SHALL be synchronous.
REQ-009 Opcode 0x0 LDA: T4 MAR<=operand; T5 ACC<=RAM[MAR].
REQ-010 Opcode 0x1 ADD: T4 MAR<=operand; T5 B<=RAM[MAR]; T6 {C,ACC}<=ACC+B.
REQ-011 Opcode 0x2 SUB: as ADD, but T6 {C,ACC}<=ACC+~B+1, so C=1 iff ACC>=B unsigned.
REQ-012 Only ADD and SUB SHALL update flags: Z<=(result==0) and C as defined, both in T6.
REQ-013 Opcode 0x3 STA: T4 MAR<=operand; T5 RAM[MAR]<=ACC.
REQ-014 Opcode 0x4 LDI: T4 ACC<=operand zero-extended to DATA_W.
REQ-015 Opcode 0x5 JMP SHALL set PC<=operand in T4; 0x6 JC SHALL do so only if C=1; 0x7 JZ SHALL do so only if Z=1.
REQ-016 Opcode 0xE OUT: T4 out<=ACC; out_valid=1 during T5 only.
REQ-017 Opcode 0xF HLT: T4 SHALL go to HALT; HALT SHALL hold until reset or prog_mode, with halted=1 and all registers frozen.
REQ-018 All other opcodes SHALL be NOPs that still take 6 cycles.
REQ-019 prog_mode=1 sampled at any edge SHALL move the FSM to LOAD on that edge and abort any in-flight instruction.
REQ-020 In LOAD, prog_we=1 SHALL write RAM[prog_addr]<=prog_data each cycle.
REQ-021 On prog_mode 1->0, the FSM SHALL go to T1 with PC, ACC, B, IR, MAR, Z and C all cleared; out SHALL be kept.
REQ-022 prog_we outside LOAD SHALL be ignored.

Reset
REQ-023 clr=0 SHALL immediately force state T1 and clear PC, MAR, IR, ACC, B, out, out_valid, Z, C and halted.
REQ-024 Reset SHALL NOT clear RAM contents.
REQ-025 Reset asserted mid-instruction, including during a T5 STA, SHALL suppress that RAM write.
REQ-026 Execution SHALL start at the first rising edge after clr deasserts, unless prog_mode=1.

Configuration
REQ-027 Macro SAP_JUMP_EN: when defined, JMP, JC and JZ SHALL behave as in REQ-015; when undefined, opcodes 0x5-0x7 SHALL be NOPs and flags SHALL still update.

Verification
REQ-028 Load RAM[0..3]={0x09,0x1A,0xE0,0xF0}, RAM[9]=5, RAM[10]=3, then run -> out=8, one out_valid pulse at cycle 17 after start (T5 of instr 3), halted=1 from cycle 24.
REQ-029 Program LDI 7; SUB 0xF with RAM[15]=7; JZ 5; OUT; HLT; at 5: LDI 1; OUT; HLT -> Z=1, C=1, out=1; with SAP_JUMP_EN undefined -> out=0.
REQ-030 LDI 15 then ADD of RAM=0xF1 -> ACC=0x00, C=1, Z=1.
REQ-031 STA 0xC with ACC=0x5A, then LDA 0xC then OUT -> out=0x5A; clr pulsed during the STA's T5 -> RAM[12] unchanged.
REQ-032 A 16-instruction NOP program with no HLT -> pc wraps from 15 to 0 and fetch continues.
REQ-033 Set ADDR_W=6, DATA_W=12; assert prog_mode mid-run, write RAM[63], release -> pc=0, the run restarts and the RAM[63] write succeeds.
